// File: rtl/decrypt_frame_ctrl_pkg.sv
// Shared types and default sizing for the decrypt frame controller and its output FIFO.
package decrypt_frame_ctrl_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } ctrl_state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/decrypt_frame_ctrl_fifo.sv
// Small synchronous FIFO that absorbs datapath results; a push onto a full FIFO
// is accepted only when a pop frees the head in the same cycle.
module ctrl_fifo
  import decrypt_frame_ctrl_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fifo_entry_t      wdata,
  input  logic             pop,
  output fifo_entry_t      rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is not reset; count gates visibility, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/decrypt_frame_ctrl.sv
// Frame sequencer for the byte-serial decrypt datapath: latches per-frame keys,
// meters ciphertext in by FIFO credit and returns plaintext with an end-of-frame marker.
module decrypt_frame_ctrl
  import decrypt_frame_ctrl_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LEN_W = DEFAULT_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [7:0]       cfg_k1,
  input  logic [7:0]       cfg_k2,
  input  logic [7:0]       cfg_k3,
  input  logic [2:0]       cfg_rot_freq,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  output logic             dp_en,
  output logic [7:0]       dp_din,
  output logic             dp_key_load,
  output logic [7:0]       dp_k1,
  output logic [7:0]       dp_k2,
  output logic [7:0]       dp_k3,
  output logic [2:0]       dp_rot_freq,
  input  logic [7:0]       dp_dout,
  input  logic             dp_v,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             busy,
  output logic             frame_done,
  output logic             err_spurious
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  ctrl_state_t      state;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] out_cnt;
  logic [1:0]       inflight;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             spurious;
  fifo_entry_t      push_entry;
  fifo_entry_t      head;

  // Credit covers both queued and in-flight results, since the datapath cannot stall.
  assign s_ready    = (state == RUN) && ((int'(fifo_count) + int'(inflight)) < DEPTH);
  assign dp_en      = s_valid && s_ready;
  assign dp_din     = dp_en ? s_data : 8'h00;

  assign spurious   = dp_v && ((state == IDLE) || (inflight == 2'd0));
  assign push       = dp_v && !spurious;
  assign push_entry = '{last: (out_cnt == LEN_W'(1)), data: dp_dout};

  assign m_valid    = !fifo_empty;
  assign pop        = m_valid && m_ready;
  assign m_data     = m_valid ? head.data : 8'h00;
  assign m_last     = m_valid && head.last;
  assign frame_done = (state == DRAIN) && pop && head.last;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cfg_ready   <= 1'b0;
      dp_key_load <= 1'b0;
      dp_k1       <= '0;
      dp_k2       <= '0;
      dp_k3       <= '0;
      dp_rot_freq <= '0;
      remaining   <= '0;
      out_cnt     <= '0;
    end else begin
      dp_key_load <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_valid && cfg_ready) begin
            dp_k1       <= cfg_k1;
            dp_k2       <= cfg_k2;
            dp_k3       <= cfg_k3;
            dp_rot_freq <= cfg_rot_freq;
            remaining   <= cfg_len;
            out_cnt     <= cfg_len;
            dp_key_load <= 1'b1;
            cfg_ready   <= 1'b0;
            state       <= LOAD;
          end else begin
            cfg_ready <= 1'b1;
          end
        end
        LOAD: state <= RUN;
        RUN: begin
          if (dp_en) begin
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (frame_done) begin
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Pushes never happen in IDLE, so this cannot collide with the length load.
      if (push) out_cnt <= out_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight     <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (spurious) err_spurious <= 1'b1;
      if (dp_en && !push)      inflight <= inflight + 1'b1;
      else if (!dp_en && push) inflight <= inflight - 1'b1;
    end
  end

  ctrl_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_decrypt_frame_ctrl.sv
// Directed bench for decrypt_frame_ctrl with a 2-cycle XOR-by-k1 datapath stand-in.
module tb_decrypt_frame_ctrl;
  import decrypt_frame_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid, cfg_ready;
  logic [LEN_W-1:0] cfg_len;
  logic [7:0]       cfg_k1, cfg_k2, cfg_k3;
  logic [2:0]       cfg_rot_freq;
  logic             s_valid, s_ready;
  logic [7:0]       s_data;
  logic             dp_en, dp_key_load, dp_v;
  logic [7:0]       dp_din, dp_k1, dp_k2, dp_k3, dp_dout;
  logic [2:0]       dp_rot_freq;
  logic             m_valid, m_ready, m_last;
  logic [7:0]       m_data;
  logic             busy, frame_done, err_spurious;

  always #5 clk = ~clk;

  decrypt_frame_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len),
    .cfg_k1(cfg_k1), .cfg_k2(cfg_k2), .cfg_k3(cfg_k3), .cfg_rot_freq(cfg_rot_freq),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .dp_en(dp_en), .dp_din(dp_din), .dp_key_load(dp_key_load),
    .dp_k1(dp_k1), .dp_k2(dp_k2), .dp_k3(dp_k3), .dp_rot_freq(dp_rot_freq),
    .dp_dout(dp_dout), .dp_v(dp_v),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .frame_done(frame_done), .err_spurious(err_spurious)
  );

  // Datapath stand-in: fixed 2-cycle latency, plaintext = ciphertext ^ loaded k1.
  logic [7:0] key_q, d1, d2;
  logic       v1, v2, inj;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= '0; d1 <= '0; d2 <= '0; v1 <= 1'b0; v2 <= 1'b0;
    end else begin
      if (dp_key_load) key_q <= dp_k1;
      v1 <= dp_en;
      d1 <= dp_din ^ key_q;
      v2 <= v1;
      d2 <= d1;
    end
  end
  assign dp_v    = v2 | inj;
  assign dp_dout = d2;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Negedge monitor: event counts and cycle stamps for the current frame.
  int         cyc = 0;
  int         kl_cnt, kl_cyc, en_cnt, first_en, last_en, first_mv;
  int         fd_cnt, fd_bad, poke_seen, poke_bad;
  logic [8:0] outq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (dp_key_load) begin
        kl_cnt <= kl_cnt + 1;
        kl_cyc <= cyc;
      end
      if (dp_en) begin
        en_cnt  <= en_cnt + 1;
        last_en <= cyc;
        if (first_en < 0) first_en <= cyc;
      end
      if (m_valid && first_mv < 0) first_mv <= cyc;
      if (m_valid && m_ready) outq.push_back({m_last, m_data});
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (frame_done && !(m_valid && m_ready && m_last)) fd_bad <= fd_bad + 1;
      if (cfg_valid && busy) begin
        poke_seen <= poke_seen + 1;
        if (cfg_ready) poke_bad <= poke_bad + 1;
      end
    end
  end

  task automatic clear_mon();
    kl_cnt = 0; kl_cyc = -100; en_cnt = 0; first_en = -1; last_en = -1; first_mv = -1;
    fd_cnt = 0; fd_bad = 0; poke_seen = 0; poke_bad = 0;
    outq.delete();
  endtask

  typedef struct {
    logic [7:0] len;
    logic [7:0] k1, k2, k3;
    logic [2:0] rot;
    logic [7:0] base;
    int         mode;   // 0: m_ready high, 1: m_ready low until credit exhausted, 2: m_ready toggling
    bit         poke;   // assert cfg_valid while the frame is running
    int         exp_n;  // bytes expected in and out
  } vec_t;

  vec_t vecs[5];
  int   cfg_cyc;

  task automatic start_cfg(input vec_t v);
    int g = 0;
    while (!cfg_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    cfg_len = v.len; cfg_k1 = v.k1; cfg_k2 = v.k2; cfg_k3 = v.k3; cfg_rot_freq = v.rot;
    cfg_valid = 1'b1;
    cfg_cyc   = cyc;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic send_bytes(input int n, input logic [7:0] base, input bit poke);
    int i = 0;
    int g = 0;
    s_data  = base;
    s_valid = 1'b1;
    while (i < n && g < 2000) begin
      @(negedge clk);
      g++;
      if (s_ready) begin
        @(posedge clk);
        i++;
        #1;
        s_data = base + 8'(i);
        if (i == n) s_valid = 1'b0;
        if (poke && i == 1) begin
          cfg_valid = 1'b1;
          cfg_k1    = ~cfg_k1;
        end else if (poke && i == 3) begin
          cfg_valid = 1'b0;
        end
      end
    end
    s_valid   = 1'b0;
    cfg_valid = 1'b0;
    check("bytes_sent", i, n);
  endtask

  task automatic sink(input int mode);
    int g = 0;
    if (mode == 0) begin
      m_ready = 1'b1;
    end else if (mode == 1) begin
      m_ready = 1'b0;
      repeat (12) @(negedge clk);
      check("stall_en_cnt", en_cnt, DEPTH);
      check("stall_s_ready", s_ready, 1'b0);
      check("stall_fifo_count", dut.u_fifo.count, DEPTH);
      m_ready = 1'b1;
    end else begin
      m_ready = 1'b0;
      while (fd_cnt == 0 && g < 3000) begin
        @(negedge clk);
        m_ready = ~m_ready;
        g++;
      end
      m_ready = 1'b1;
    end
  endtask

  task automatic run_frame(input vec_t v, input int vi);
    int         g = 0;
    logic [7:0] exp_d;
    logic [8:0] exp_e;
    clear_mon();
    start_cfg(v);
    fork
      send_bytes(v.exp_n, v.base, v.poke);
      sink(v.mode);
    join
    while (fd_cnt == 0 && g < 600) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    check($sformatf("f%0d_key_load_cnt", vi), kl_cnt, 1);
    check($sformatf("f%0d_key_load_lat", vi), kl_cyc - cfg_cyc, 1);
    check($sformatf("f%0d_keys", vi), {dp_k1, dp_k2, dp_k3, dp_rot_freq}, {v.k1, v.k2, v.k3, v.rot});
    check($sformatf("f%0d_first_s_ready", vi), first_en - cfg_cyc, 2);
    check($sformatf("f%0d_dp_en_cnt", vi), en_cnt, v.exp_n);
    check($sformatf("f%0d_m_latency", vi), first_mv - first_en, 3);
    if (v.mode == 0) check($sformatf("f%0d_dp_en_burst", vi), last_en - first_en, v.exp_n - 1);
    check($sformatf("f%0d_out_count", vi), outq.size(), v.exp_n);
    for (int i = 0; i < outq.size(); i++) begin
      exp_d = (v.base + 8'(i)) ^ v.k1;
      exp_e = {(i == v.exp_n - 1), exp_d};
      check($sformatf("f%0d_byte%0d", vi, i), outq[i], exp_e);
    end
    check($sformatf("f%0d_frame_done_cnt", vi), fd_cnt, 1);
    check($sformatf("f%0d_frame_done_with_last", vi), fd_bad, 0);
    check($sformatf("f%0d_idle_after", vi), {busy, cfg_ready}, 2'b01);
    if (v.poke) begin
      check($sformatf("f%0d_poke_seen", vi), poke_seen > 0, 1'b1);
      check($sformatf("f%0d_poke_ready_low", vi), poke_bad, 0);
    end
  endtask

  initial begin
    vec_t rv;
    rst = 1'b1; inj = 1'b0;
    cfg_valid = 1'b0; cfg_len = '0; cfg_k1 = '0; cfg_k2 = '0; cfg_k3 = '0; cfg_rot_freq = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    clear_mon();

    vecs[0] = '{len: 8'd4,  k1: 8'h11, k2: 8'h22, k3: 8'h33, rot: 3'd1, base: 8'h00, mode: 0, poke: 1'b0, exp_n: 4};
    vecs[1] = '{len: 8'd10, k1: 8'hA5, k2: 8'h5A, k3: 8'h0F, rot: 3'd3, base: 8'h30, mode: 1, poke: 1'b0, exp_n: 10};
    vecs[2] = '{len: 8'd6,  k1: 8'h3C, k2: 8'hC3, k3: 8'h99, rot: 3'd5, base: 8'hF0, mode: 2, poke: 1'b1, exp_n: 6};
    vecs[3] = '{len: 8'd0,  k1: 8'h81, k2: 8'h42, k3: 8'h24, rot: 3'd7, base: 8'h10, mode: 0, poke: 1'b0, exp_n: 256};
    vecs[4] = '{len: 8'd1,  k1: 8'h7E, k2: 8'h01, k3: 8'h02, rot: 3'd0, base: 8'hAA, mode: 0, poke: 1'b0, exp_n: 1};

    repeat (2) @(negedge clk);
    check("reset_outputs",
          {cfg_ready, s_ready, dp_en, dp_din, dp_key_load, dp_k1, dp_k2, dp_k3, dp_rot_freq,
           m_valid, m_data, m_last, busy, frame_done, err_spurious}, '0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("after_release", {cfg_ready, busy}, 2'b10);

    for (int vi = 0; vi < 5; vi++) run_frame(vecs[vi], vi);

    // Reset in the middle of a 5-byte frame with two results queued.
    clear_mon();
    m_ready = 1'b0;
    rv = '{len: 8'd5, k1: 8'h5A, k2: 8'h00, k3: 8'h00, rot: 3'd2, base: 8'h40, mode: 1, poke: 1'b0, exp_n: 5};
    start_cfg(rv);
    send_bytes(2, 8'h40, 1'b0);
    repeat (3) @(negedge clk);
    check("midrst_fifo_before", dut.u_fifo.count, 2);
    check("midrst_busy_before", {busy, m_valid}, 2'b11);
    rst = 1'b1;
    #1;
    check("midrst_during", {busy, m_valid, s_ready, cfg_ready, m_data}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_after", {cfg_ready, busy, m_valid, err_spurious}, 4'b1000);
    check("midrst_fifo_after", dut.u_fifo.count, 0);

    // Result strobe with nothing in flight while idle.
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    @(negedge clk);
    check("spurious_set", {err_spurious, m_valid, busy}, 3'b100);
    repeat (3) @(negedge clk);
    check("spurious_sticky", err_spurious, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("spurious_cleared_by_rst", err_spurious, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/decrypt_frame_ctrl.md
# decrypt_frame_ctrl

Frame sequencer and flow-control wrapper for the byte-serial decrypt datapath. Accepts a per-frame configuration (length, three XOR key bytes, rotation frequency), reloads the datapath key at frame start, and feeds ciphertext bytes into it under a valid/ready handshake. Decrypted bytes return into an internal FIFO that absorbs the datapath's fixed 2-cycle, non-stallable pipeline. The FIFO presents them downstream with valid/ready and an end-of-frame marker.

## Interface
- DEPTH, 4: output FIFO entries; must be ≥ 3 to sustain one byte/cycle
- LEN_W, 8: width of frame length field; length 0 encodes 2^LEN_W bytes
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_valid / cfg_ready  in / out  1  frame configuration handshake
- cfg_len  in  LEN_W  frame length in bytes
- cfg_k1, cfg_k2, cfg_k3  in  8  XOR key bytes
- cfg_rot_freq  in  3  key rotation frequency
- s_valid / s_ready  in / out  1  ciphertext input handshake
- s_data  in  8  ciphertext byte
- dp_en  out  1  datapath byte strobe
- dp_din  out  8  byte to datapath
- dp_key_load  out  1  one-cycle pulse; datapath reloads its key from dp_k*
- dp_k1, dp_k2, dp_k3  out  8  latched keys
- dp_rot_freq  out  3  latched rotation frequency
- dp_dout  in  8  datapath result
- dp_v  in  1  datapath result valid
- m_valid / m_ready  out / in  1  plaintext output handshake
- m_data  out  8  plaintext byte
- m_last  out  1  marks the final byte of a frame
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when the last byte is accepted downstream
- err_spurious  out  1  sticky flag: dp_v seen with nothing in flight; cleared only by rst

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN.
- IDLE
  - cfg_ready = 1.
  - On cfg_valid: latch cfg_* into dp_* registers, load remaining = cfg_len and out_cnt = cfg_len, then go to LOAD.
- LOAD
  - Lasts exactly 1 cycle; dp_key_load = 1; then go to RUN.
- RUN
  - s_ready = (fifo_count + inflight < DEPTH).
  - On s_valid & s_ready:
    - dp_en = 1 and dp_din = s_data, both combinational pass-through.
    - remaining decrements, wrapping 0 → all-ones.
    - When remaining == 1 at the handshake, go to DRAIN.
- DRAIN
  - s_ready = 0.
  - When the m_last entry handshakes (m_valid & m_ready & m_last): pulse frame_done and go to IDLE.
- inflight counter (0..2)
  - +1 on dp_en, −1 on dp_v; both together leave it unchanged.
- Results
  - Each dp_v pushes {last, dp_dout} into the FIFO.
  - out_cnt decrements per push; last = (out_cnt == 1).
  - In IDLE, dp_v is dropped and err_spurious is set.
- The credit rule guarantees the FIFO never overflows. An overflow attempt is an assertion failure.
- cfg_valid outside IDLE is ignored; cfg_ready = 0 there.

## Timing
- Reset values
  - All outputs 0, except cfg_ready = 0 while rst is high and 1 in the first cycle after release.
  - State IDLE; counters 0; FIFO empty; err_spurious 0.
- cfg handshake → dp_key_load: 1 cycle.
- First s_ready: 2 cycles after the cfg handshake.
- dp_en (cycle t) → dp_v (t+2) → FIFO push at t+2 edge → m_valid at t+3.
  - Minimum s-to-m latency is 3 cycles.
- Throughput is 1 byte/cycle with m_ready held high and DEPTH ≥ 3.
- m_valid = FIFO not empty; m_data and m_last come from the FIFO head and stay stable while m_valid & !m_ready.
- FIFO push and pop in the same cycle on a full FIFO is legal only if the credit rule held; count is unchanged.
- Back-to-back frames
  - The next cfg handshake is accepted in the cycle after frame_done (IDLE).
  - There is no overlap of frames.
- rst mid-frame: immediate return to IDLE and FIFO flush. Datapath results already in flight are dropped as spurious.
  - The datapath shares rst, so no results should arrive in this case.

## Structure
- Shared package
  - ctrl_state_t enum {IDLE, LOAD, RUN, DRAIN}.
  - fifo_entry_t struct {logic last; logic [7:0] data}.
  - Default DEPTH / LEN_W constants.
- Sub-module ctrl_fifo
  - Synchronous FIFO of fifo_entry_t, parameter DEPTH.
  - Exposes count, full, empty.
  - Instantiated once.
- The FSM and counters live in decrypt_frame_ctrl; the datapath is instantiated by the parent, not inside this block.

## Test plan
- Reset, then idle: all outputs 0 during rst; cfg_ready = 1 the cycle after release; busy = 0.
- Frame len = 4, keys 0x11/0x22/0x33, s_valid held high, m_ready held high:
  - dp_key_load pulses once; dp_en is high for 4 consecutive cycles.
  - m_valid rises 3 cycles after the first dp_en.
  - m_last is set on the 4th byte only; frame_done pulses the same cycle.
- Backpressure, len = 10, m_ready = 0 throughout:
  - s_ready drops after DEPTH bytes issued; FIFO count = 4; no overflow.
  - Releasing m_ready drains all 10 bytes in order.
- len = 0 with LEN_W = 8: exactly 256 bytes accepted; m_last on byte 256.
- cfg_valid asserted during RUN: ignored, cfg_ready = 0. After frame_done, the next cfg is accepted and dp_key_load re-pulses.
- Faults: rst asserted mid-frame after 2 of 5 bytes returns to IDLE and empties the FIFO; a dp_v injected in IDLE sets err_spurious.
